// File: rtl/uart_cmd_responder_pkg.sv
// rtl/uart_cmd_responder_pkg.sv - opcode/reply constants and FSM encoding for the UART command responder
package uart_cmd_responder_pkg;

    localparam logic [7:0] OP_WRITE     = 8'h57;
    localparam logic [7:0] OP_READ      = 8'h52;
    localparam logic [7:0] RSP_OK       = 8'h4B;
    localparam logic [7:0] RSP_ERR_ADDR = 8'h21;
    localparam logic [7:0] RSP_ERR_OP   = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_EXEC     = 3'd3,
        ST_REPLY    = 3'd4
    } state_t;

    // Only W and R open a multi-byte frame; anything else is answered at once.
    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// rtl/uart_cmd_responder_if.sv - receive/transmit FIFO handshake bundle
interface uart_cmd_responder_if;

    logic [7:0] r_data;
    logic       rx_empty;
    logic       rd;
    logic [7:0] w_data;
    logic       wr;
    logic       tx_full;

    // master: the responder, which pops the RX FIFO and pushes the TX FIFO
    modport master (
        input  r_data,
        input  rx_empty,
        input  tx_full,
        output rd,
        output w_data,
        output wr
    );

    // slave: the FIFO pair
    modport slave (
        output r_data,
        output rx_empty,
        output tx_full,
        input  rd,
        input  w_data,
        input  wr
    );

endinterface

// File: rtl/uart_cmd_responder_regfile.sv
// rtl/uart_cmd_responder_regfile.sv - DEPTH x 8 register bank, one write port, async read, reg0 tap
module uart_cmd_regfile #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [7:0]    reg0
);

    logic [7:0] mem [DEPTH];

    // Bank storage: cleared by reset, written only on the single write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
    assign reg0  = mem[0];

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - UART command frame parser, register access and single-byte replier
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_cmd_responder_if.master  bus,
    output logic [7:0]            reg0_out,
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    op_q;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    reply_q;
    logic [7:0]    reply_next;
    logic          rd_q;
    logic          rd_next;
    logic          wr_q;
    logic          wr_next;
    logic [TW-1:0] tmo_q;
    logic          consume;
    logic          in_frame;
    logic          timed_out;
    logic          addr_ok;
    logic          reg_we;
    logic [7:0]    reg_rdata;

    // A byte is taken only when the previous cycle did not pop, since the
    // FIFO head only advances on the edge that ends the rd cycle.
    assign consume = ((state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA))
                     && !bus.rx_empty && !rd_q;
    assign in_frame  = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign timed_out = in_frame && !consume && (tmo_q == TO_LAST);
    // Full 8-bit compare so out-of-range addresses never alias onto the bank.
    assign addr_ok   = ({1'b0, addr_q} < 9'(DEPTH));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: frame parsing, timeout abort, reply hand-off.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (consume) begin
                    state_next = is_known_op(bus.r_data) ? ST_GET_ADDR : ST_REPLY;
                end
            end
            ST_GET_ADDR: begin
                if (consume) begin
                    state_next = (op_q == OP_WRITE) ? ST_GET_DATA : ST_EXEC;
                end else if (timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (consume) begin
                    state_next = ST_EXEC;
                end else if (timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_EXEC:  state_next = ST_REPLY;
            ST_REPLY: begin
                if (wr_q) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output logic: pop/push strobes, register write enable, reply byte select.
    // wr is armed on the edge into (or while in) REPLY so the push lands in
    // the first REPLY cycle; we are the only writer, so tx_full cannot rise
    // underneath an armed push.
    always_comb begin
        rd_next    = consume;
        wr_next    = (state_next == ST_REPLY) && !bus.tx_full;
        reg_we     = (state == ST_EXEC) && (op_q == OP_WRITE) && addr_ok;
        reply_next = reply_q;
        if ((state == ST_IDLE) && consume && !is_known_op(bus.r_data)) begin
            reply_next = RSP_ERR_OP;
        end else if (state == ST_EXEC) begin
            if (!addr_ok) begin
                reply_next = RSP_ERR_ADDR;
            end else if (op_q == OP_WRITE) begin
                reply_next = RSP_OK;
            end else begin
                reply_next = reg_rdata;
            end
        end
    end

    // Datapath registers: strobes, frame bytes, reply byte, inactivity counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            reply_q <= 8'h00;
            op_q    <= 8'h00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            tmo_q   <= '0;
        end else begin
            rd_q    <= rd_next;
            wr_q    <= wr_next;
            reply_q <= reply_next;
            if (consume) begin
                case (state)
                    ST_IDLE:     op_q   <= bus.r_data;
                    ST_GET_ADDR: addr_q <= bus.r_data;
                    ST_GET_DATA: data_q <= bus.r_data;
                    default:     ;
                endcase
            end
            if (consume || !in_frame) begin
                tmo_q <= '0;
            end else if (tmo_q != '1) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    uart_cmd_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (reg_we),
        .addr  (addr_q[AW-1:0]),
        .wdata (data_q),
        .rdata (reg_rdata),
        .reg0  (reg0_out)
    );

    assign bus.rd     = rd_q;
    assign bus.wr     = wr_q;
    assign bus.w_data = reply_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - scoreboard bench for uart_cmd_responder
module tb_uart_cmd_responder;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] reg0_out;
    logic       busy;

    always #5 clock = ~clock;

    uart_cmd_responder_if bus ();

    uart_cmd_responder #(
        .DEPTH   (16),
        .TIMEOUT (100)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .reg0_out (reg0_out),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] reg0;
    } exp_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } probe_t;

    exp_t       expq[$];
    probe_t     probes[$];
    logic [7:0] rxq[$];
    int         checks = 0;
    int         failures = 0;
    int         wr_count = 0;
    int         exp_wr_total = 0;
    logic [7:0] exp_reg0 = 8'h00;
    logic       prev_wr = 1'b0;
    logic       prev_rd = 1'b0;

    // Receive FIFO model: pop on rd, present head byte mid-cycle.
    always @(negedge clock) begin
        if (bus.rd && rxq.size() > 0) begin
            void'(rxq.pop_front());
        end
        bus.rx_empty = (rxq.size() == 0);
        bus.r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    // Monitor: evaluates snapshot probes and scores every pushed reply.
    always @(negedge clock) begin
        logic [31:0] act;
        probe_t      p;
        exp_t        e;
        while (probes.size() > 0) begin
            p = probes.pop_front();
            case (p.sel)
                0:       act = 32'(busy);
                1:       act = 32'(reg0_out);
                2:       act = 32'(bus.rd);
                3:       act = 32'(bus.wr);
                4:       act = 32'(bus.w_data);
                5:       act = 32'(wr_count);
                default: act = 32'(expq.size());
            endcase
            checks++;
            if (act !== p.exp) begin
                failures++;
                $display("FAIL %s actual=%0h required=%0h", p.name, act, p.exp);
            end
        end
        if (!reset && bus.rd) begin
            checks++;
            if (prev_rd) begin
                failures++;
                $display("FAIL rd_consecutive actual=1 required=0");
            end
        end
        if (!reset && bus.wr) begin
            wr_count++;
            checks++;
            if (prev_wr) begin
                failures++;
                $display("FAIL wr_consecutive actual=1 required=0");
            end
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_wr actual=%02h required=none", bus.w_data);
            end else begin
                e = expq.pop_front();
                if (bus.w_data !== e.data) begin
                    failures++;
                    $display("FAIL reply_byte actual=%02h required=%02h", bus.w_data, e.data);
                end
                checks++;
                if (reg0_out !== e.reg0) begin
                    failures++;
                    $display("FAIL reg0_at_reply actual=%02h required=%02h", reg0_out, e.reg0);
                end
            end
        end
        prev_wr = bus.wr;
        prev_rd = bus.rd;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic expect_reply(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.reg0 = exp_reg0;
        expq.push_back(e);
        exp_wr_total++;
    endtask

    task automatic probe(input string n, input int sel, input logic [31:0] e);
        probe_t p;
        p.name = n;
        p.sel  = sel;
        p.exp  = e;
        probes.push_back(p);
    endtask

    task automatic drain(input string n);
        int k = 0;
        while ((rxq.size() != 0 || expq.size() != 0 || busy) && k < 400) begin
            tick(1);
            k++;
        end
        tick(1);
        probe({n, "_idle"}, 0, 0);
        probe({n, "_scoreboard_empty"}, 6, 0);
        tick(1);
    endtask

    task automatic wait_rx_empty();
        int k = 0;
        while (rxq.size() != 0 && k < 50) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.tx_full = 1'b0;
        tick(3);
        reset = 1'b0;
        probe("reset_rd", 2, 0);
        probe("reset_wr", 3, 0);
        probe("reset_w_data", 4, 8'h00);
        probe("reset_reg0", 1, 8'h00);
        probe("reset_busy", 0, 0);
        tick(2);

        // write reg3 then read it back
        send(8'h57); send(8'h03); send(8'hA5); expect_reply(8'h4B);
        send(8'h52); send(8'h03);              expect_reply(8'hA5);
        drain("wr_rd_reg3");

        // write reg0, visible on LEDs by the push cycle
        exp_reg0 = 8'h3C;
        send(8'h57); send(8'h00); send(8'h3C); expect_reply(8'h4B);
        drain("wr_reg0");
        probe("reg0_after_write", 1, 8'h3C);

        // address and opcode errors, depth boundary
        send(8'h52); send(8'h20);              expect_reply(8'h21);
        send(8'h41);                           expect_reply(8'h3F);
        send(8'h52); send(8'h0F);              expect_reply(8'h00);
        send(8'h57); send(8'h10); send(8'hFF); expect_reply(8'h21);
        send(8'h52); send(8'h10);              expect_reply(8'h21);
        drain("errors");

        // transmit FIFO full holds the reply
        bus.tx_full = 1'b1;
        send(8'h52); send(8'h03);              expect_reply(8'hA5);
        tick(25);
        probe("txfull_busy", 0, 1);
        probe("txfull_no_wr", 5, 32'(exp_wr_total - 1));
        tick(1);
        bus.tx_full = 1'b0;
        drain("txfull_release");
        probe("txfull_one_wr", 5, 32'(exp_wr_total));

        // partial frame abandoned by inactivity timeout
        send(8'h57); send(8'h05);
        wait_rx_empty();
        tick(50);
        probe("timeout_still_busy", 0, 1);
        tick(52);
        probe("timeout_idle", 0, 0);
        probe("timeout_no_wr", 5, 32'(exp_wr_total));
        tick(1);
        send(8'h52); send(8'h05);              expect_reply(8'h00);
        drain("timeout_readback");

        // reset mid-frame
        send(8'h57); send(8'h01);
        wait_rx_empty();
        tick(2);
        reset = 1'b1;
        tick(2);
        reset    = 1'b0;
        exp_reg0 = 8'h00;
        probe("midreset_busy", 0, 0);
        probe("midreset_reg0", 1, 8'h00);
        probe("midreset_wr", 3, 0);
        tick(1);
        send(8'h57); send(8'h01); send(8'h77); expect_reply(8'h4B);
        send(8'h52); send(8'h01);              expect_reply(8'h77);
        send(8'h52); send(8'h03);              expect_reply(8'h00);
        send(8'h52); send(8'h00);              expect_reply(8'h00);
        drain("after_reset");
        probe("total_wr", 5, 32'(exp_wr_total));

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
